pc_sequencer: RTL and testbench

Fetch sequencer for the single-cycle RISC-V core. It owns the program counter register and decides its next value each instruction: sequential, branch, jump or trap vector. It runs a request/acknowledge handshake with instruction memory, presents one validated instruction slot per fetch to the datapath, and counts retired instructions. It sits between the datapath's branch/jump resolution logic and instruction memory.

---
 rtl/pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch sequencer: owns the PC, runs the imem request/ack handshake,
// validates one instruction slot per fetch and counts retirements.
module pc_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'd0,
    parameter logic [63:0] TRAP_VECTOR  = 64'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        jump,
    input  logic [63:0] jump_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    output logic        instr_valid,
    output logic [63:0] PC_Out,
    output logic        misaligned,
    output logic [63:0] instret
);

    localparam int unsigned XLEN     = 64;
    localparam int unsigned PC_STEP  = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_next_pc;
    logic [XLEN-1:0]   r_instret;
    logic [XLEN-1:0]   w_next_instret;
    logic              r_misaligned;
    logic              w_next_misaligned;
    logic              r_imem_req;
    logic              r_instr_valid;

    logic              w_redirect;
    logic [XLEN-1:0]   w_target;
    logic              w_target_bad;

    // Non-trap next-PC candidate: jump beats branch beats sequential.
    always_comb begin
        w_redirect = 1'b0;
        w_target   = r_pc + XLEN'(PC_STEP);
        if (jump) begin
            w_redirect = 1'b1;
            w_target   = jump_target;
        end else if (branch_taken) begin
            w_redirect = 1'b1;
            w_target   = branch_target;
        end
    end

    assign w_target_bad = w_redirect && (w_target[1:0] != 2'b00);

    // Next-state, next-PC and retirement logic.
    always_comb begin
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_instret    = r_instret;
        w_next_misaligned = r_misaligned;
        case (r_state)
            ST_BOOT: begin
                w_next_state = ST_FETCH;
                if (trap) begin
                    w_next_pc = TRAP_VECTOR;
                end
            end
            ST_FETCH: begin
                if (trap) begin
                    w_next_pc    = TRAP_VECTOR;
                    w_next_state = ST_FETCH;
                end else if (imem_ack) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_instret = r_instret + XLEN'(1);
                if (trap) begin
                    w_next_pc    = TRAP_VECTOR;
                    w_next_state = ST_FETCH;
                end else begin
                    w_next_state = halt ? ST_HALT : ST_FETCH;
                    if (w_target_bad) begin
                        w_next_pc         = TRAP_VECTOR;
                        w_next_misaligned = 1'b1;
                    end else begin
                        w_next_pc = w_target;
                    end
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= RESET_VECTOR;
            r_instret    <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_pc         <= w_next_pc;
            r_instret    <= w_next_instret;
            r_misaligned <= w_next_misaligned;
        end
    end

    // Handshake outputs are registered from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_imem_req    <= (w_next_state == ST_FETCH);
            r_instr_valid <= (w_next_state == ST_EXEC);
        end
    end

    assign imem_req    = r_imem_req;
    assign instr_valid = r_instr_valid;
    assign imem_addr   = r_pc;
    assign PC_Out      = r_pc;
    assign misaligned  = r_misaligned;
    assign instret     = r_instret;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        jump;
    logic [63:0] jump_target;
    logic        trap;
    logic        halt;
    logic        imem_ack;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        instr_valid;
    logic [63:0] PC_Out;
    logic        misaligned;
    logic [63:0] instret;

    int n_cmp;
    int n_err;
    int req_cnt;
    int val_cnt;

    pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .halt          (halt),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .instr_valid   (instr_valid),
        .PC_Out        (PC_Out),
        .misaligned    (misaligned),
        .instret       (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; req_cnt = 0; val_cnt = 0;
        reset = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0; trap = 1'b0; halt = 1'b0;
        imem_ack = 1'b1;

        repeat (2) tick();
        chk("rst_pc", PC_Out, 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_mis", 64'(misaligned), 64'd0);
        reset = 1'b1;

        // Sequential fetch with zero wait states
        tick();
        chk("boot_fetch_req", 64'(imem_req), 64'd1);
        chk("boot_fetch_pc", PC_Out, 64'd0);
        chk("boot_fetch_addr", imem_addr, 64'd0);
        tick();
        chk("exec0_valid", 64'(instr_valid), 64'd1);
        chk("exec0_req", 64'(imem_req), 64'd0);
        tick();
        chk("fetch4_pc", PC_Out, 64'd4);
        chk("fetch4_instret", instret, 64'd1);
        tick();
        chk("exec4_valid", 64'(instr_valid), 64'd1);
        imem_ack = 1'b0;

        // Three wait states at PC=8
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wait_pc", PC_Out, 64'd8);
            req_cnt += int'(imem_req);
            val_cnt += int'(instr_valid);
            if (i == 3) imem_ack = 1'b1;
        end
        chk("wait_req_cycles", 64'(req_cnt), 64'd4);
        chk("wait_valid_pulses", 64'(val_cnt), 64'd1);
        tick();
        chk("after_wait_pc", PC_Out, 64'd12);
        chk("after_wait_instret", instret, 64'd3);
        tick();
        tick();
        chk("seq_pc16", PC_Out, 64'd16);
        chk("seq_instret4", instret, 64'd4);

        // Jump beats branch; branch ignored outside EXEC
        tick();
        chk("exec16_valid", 64'(instr_valid), 64'd1);
        jump = 1'b1; jump_target = 64'd2048;
        branch_taken = 1'b1; branch_target = 64'd4096;
        tick();
        chk("jump_prio_pc", PC_Out, 64'd2048);
        jump = 1'b0;
        tick();
        chk("branch_in_fetch_ignored", PC_Out, 64'd2048);
        chk("exec2048_valid", 64'(instr_valid), 64'd1);
        tick();
        chk("branch_pc", PC_Out, 64'd4096);
        chk("branch_instret", instret, 64'd6);
        branch_taken = 1'b0;

        // Misaligned branch target
        tick();
        branch_taken = 1'b1; branch_target = 64'd4098;
        tick();
        chk("mis_pc", PC_Out, 64'd1024);
        chk("mis_flag", 64'(misaligned), 64'd1);
        branch_taken = 1'b0;
        tick();
        tick();
        chk("mis_seq_pc", PC_Out, 64'd1028);
        chk("mis_sticky", 64'(misaligned), 64'd1);
        chk("mis_instret", instret, 64'd8);

        // Trap with ack in FETCH
        trap = 1'b1;
        tick();
        chk("fetch_trap_pc", PC_Out, 64'd1024);
        chk("fetch_trap_valid", 64'(instr_valid), 64'd0);
        chk("fetch_trap_req", 64'(imem_req), 64'd1);
        chk("fetch_trap_instret", instret, 64'd8);
        trap = 1'b0;

        // Trap plus halt in EXEC: trap wins
        tick();
        chk("exec1024_valid", 64'(instr_valid), 64'd1);
        trap = 1'b1; halt = 1'b1;
        tick();
        chk("exec_trap_pc", PC_Out, 64'd1024);
        chk("exec_trap_req", 64'(imem_req), 64'd1);
        chk("exec_trap_instret", instret, 64'd9);
        trap = 1'b0; halt = 1'b0;

        // PC wrap
        tick();
        jump = 1'b1; jump_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        chk("jump_top_pc", PC_Out, 64'hFFFF_FFFF_FFFF_FFFC);
        jump = 1'b0;
        tick();
        tick();
        chk("wrap_pc", PC_Out, 64'd0);
        chk("wrap_instret", instret, 64'd11);

        // Halt
        tick();
        chk("exec0b_valid", 64'(instr_valid), 64'd1);
        halt = 1'b1;
        tick();
        chk("halt_pc", PC_Out, 64'd4);
        chk("halt_instret", instret, 64'd12);
        for (int i = 0; i < 10; i++) begin
            imem_ack = 1'b1;
            trap = i[0];
            jump = ~i[0]; jump_target = 64'd64;
            branch_taken = 1'b1; branch_target = 64'd128;
            halt = i[1];
            tick();
            chk("halt_req", 64'(imem_req), 64'd0);
            chk("halt_valid", 64'(instr_valid), 64'd0);
            chk("halt_hold_pc", PC_Out, 64'd4);
            chk("halt_hold_instret", instret, 64'd12);
        end
        chk("halt_mis", 64'(misaligned), 64'd1);
        trap = 1'b0; jump = 1'b0; branch_taken = 1'b0; halt = 1'b0;

        // Reset out of HALT
        #2 reset = 1'b0;
        #1;
        chk("halt_rst_pc", PC_Out, 64'd0);
        chk("halt_rst_mis", 64'(misaligned), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("refetch_req", 64'(imem_req), 64'd1);
        tick();
        branch_taken = 1'b1; branch_target = 64'd4098;
        tick();
        chk("pre_rst_pc", PC_Out, 64'd1024);
        chk("pre_rst_mis", 64'(misaligned), 64'd1);
        chk("pre_rst_instret", instret, 64'd1);
        branch_taken = 1'b0; imem_ack = 1'b0;
        tick();
        chk("pre_rst_req", 64'(imem_req), 64'd1);

        // Asynchronous reset mid-fetch, between clock edges
        #2 reset = 1'b0;
        #1;
        chk("async_rst_pc", PC_Out, 64'd0);
        chk("async_rst_req", 64'(imem_req), 64'd0);
        chk("async_rst_instret", instret, 64'd0);
        chk("async_rst_mis", 64'(misaligned), 64'd0);
        chk("async_rst_valid", 64'(instr_valid), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
